// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16/8 divider: default widths,
// FSM state encoding and the quotient returned on a zero divisor.
package div_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Saturated quotient reported when the divisor is zero.
    localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare the partial remainder against
// the divisor and subtract when it fits.
module div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   part_rem_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    // Subtract the divisor when the partial remainder is at least as large.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        rem_o   = part_rem_i[W-1:0];
        q_bit_o = 1'b0;
        if (part_rem_i >= {1'b0, divisor_i}) begin
            // The difference is below the divisor, so it fits in W bits.
            rem_o   = W'(part_rem_i - {1'b0, divisor_i});
            q_bit_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div_16x8.sv
// Sequential restoring divider: accepts a dividend/divisor pair, produces one
// quotient bit per cycle MSB first, and holds the result until consumed.
// A zero divisor short-circuits straight to the result state with a flag.
module seq_div_16x8
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  div_by_zero
);

    localparam int             CNT_W    = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIVISOR_W-1:0]    rem_q;
    // Dividend bits shift out at the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0]   shreg_q;
    logic [DIVISOR_W-1:0]    divisor_q;
    logic                    dbz_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic [DIVISOR_W:0]      part_rem_d;
    logic [DIVISOR_W-1:0]    step_rem_d;
    logic                    q_bit_d;

    assign part_rem_d = {rem_q, shreg_q[DIVIDEND_W-1]};

    div_step #(
        .W (DIVISOR_W)
    ) u_step (
        .part_rem_i (part_rem_d),
        .divisor_i  (divisor_q),
        .rem_o      (step_rem_d),
        .q_bit_o    (q_bit_d)
    );

    // Control FSM and datapath registers, with registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            shreg_q     <= '0;
            divisor_q   <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        divisor_q  <= divisor;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            shreg_q     <= DIVIDEND_W'(DBZ_QUOT);
                            rem_q       <= dividend[DIVISOR_W-1:0];
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            shreg_q <= dividend;
                            rem_q   <= '0;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= step_rem_d;
                    shreg_q <= {shreg_q[DIVIDEND_W-2:0], q_bit_d};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quot        = shreg_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_16x8.sv
// Scoreboard bench for seq_div_16x8: the driver pushes expected results on
// each accept, a negedge monitor pops and compares on every handshake.
module tb_seq_div_16x8;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    localparam int N_RAND = 2000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        div_by_zero;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_results = 0;
    int   n_accepts = 0;

    seq_div_16x8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_results++;
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quot", 32'(quot), 32'(e.q));
                check("rem", 32'(rem), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
            end
        end
    end

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic do_accept(input logic [15:0] dvd, input logic [7:0] dsr,
                             input logic [15:0] eq, input logic [7:0] er, input logic ez);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back('{eq, er, ez});
        n_accepts++;
        #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (in_ready && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("back_to_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int highs;
        int guard;
        int n_acc;
        bit has_op;
        bit accept;
        logic [15:0] op_dvd;
        logic [7:0]  op_dsr;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        // 1000 / 7 = 142 r 6, result 16 edges after accept.
        do_accept(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        wait_out(lat);
        check("lat_1000_7", 32'(lat), 32'd16);
        wait_idle();

        do_accept(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
        wait_out(lat);
        check("lat_65535_1", 32'(lat), 32'd16);
        wait_idle();

        do_accept(16'd255, 8'd255, 16'd1, 8'd0, 1'b0);
        wait_out(lat);
        wait_idle();

        // Zero divisor: DONE is entered on the accept edge itself.
        do_accept(16'd100, 8'd0, 16'hFFFF, 8'd100, 1'b1);
        wait_out(lat);
        check("lat_dbz_valid_after_accept_edge", 32'(lat), 32'd0);
        wait_idle();

        // 50000 / 200 = 250 r 0 with the consumer stalled for 5 cycles.
        out_ready = 1'b0;
        do_accept(16'd50000, 8'd200, 16'd250, 8'd0, 1'b0);
        wait_out(lat);
        check("lat_50000_200", 32'(lat), 32'd16);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_quot", 32'(quot), 32'd250);
            check("stall_rem", 32'(rem), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_in_ready", 32'(in_ready), 32'd1);
        check("stall_release_out_valid", 32'(out_valid), 32'd0);

        // Reset after the 8th CALC edge of 1000/7 aborts the operation.
        do_accept(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        n_accepts--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) highs++;
            @(posedge clk);
            #1;
        end
        check("abort_never_valid", 32'(highs), 32'd0);
        do_accept(16'd9, 8'd2, 16'd4, 8'd1, 1'b0);
        wait_out(lat);
        check("lat_9_2", 32'(lat), 32'd16);
        wait_idle();

        // Random operands with random in_valid/out_ready; junk is driven while busy.
        has_op = 1'b0;
        n_acc  = 0;
        guard  = 0;
        op_dvd = '0;
        op_dsr = '0;
        while (n_acc < N_RAND && guard < 90000) begin
            if (!has_op) begin
                op_dsr = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                op_dvd = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                has_op = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_ready) begin
                in_valid = ($urandom_range(0, 3) != 0);
                dividend = op_dvd;
                divisor  = op_dsr;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            accept = in_valid && in_ready;
            @(posedge clk);
            if (accept) begin
                if (op_dsr == 8'd0)
                    sb.push_back('{16'hFFFF, op_dvd[7:0], 1'b1});
                else
                    sb.push_back('{op_dvd / 16'(op_dsr), 8'(op_dvd % 16'(op_dsr)), 1'b0});
                n_acc++;
                n_accepts++;
                has_op = 1'b0;
            end
            guard++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("rand_accepted", 32'(n_acc), 32'(N_RAND));
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("one_result_per_accept", 32'(n_results), 32'(n_accepts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
